// File: rtl/depth_neighbor_fetcher_if.sv
// Pixel-in / neighbourhood-triple-out bundle for depth_neighbor_fetcher.
// The master side drives pixels; the slave side (the fetcher) returns ready and triples.
interface depth_neighbor_fetcher_if #(
    parameter int DATA_DEPTH_BW = 16,
    parameter int H_SIZE_BW     = 10,
    parameter int V_SIZE_BW     = 9
);
    logic                     i_valid;
    logic                     i_sof;
    logic [DATA_DEPTH_BW-1:0] i_depth;
    logic                     o_ready;
    logic                     o_valid;
    logic [DATA_DEPTH_BW-1:0] o_depth_0;
    logic [DATA_DEPTH_BW-1:0] o_depth_u;
    logic [DATA_DEPTH_BW-1:0] o_depth_v;
    logic [H_SIZE_BW-1:0]     o_u;
    logic [V_SIZE_BW-1:0]     o_v;
    logic                     o_frame_done;

    modport master (
        output i_valid, i_sof, i_depth,
        input  o_ready, o_valid, o_depth_0, o_depth_u, o_depth_v, o_u, o_v, o_frame_done
    );

    modport slave (
        input  i_valid, i_sof, i_depth,
        output o_ready, o_valid, o_depth_0, o_depth_u, o_depth_v, o_u, o_v, o_frame_done
    );
endinterface

// File: rtl/depth_neighbor_fetcher.sv
// Raster depth streamer emitting d(u,v), d(u+1,v), d(u,v+1) per pixel from a one-row line buffer; 1-cycle latency.
// Input stalls (o_ready low) only while the last row is flushed for IMG_WID cycles; no output backpressure.
module depth_neighbor_fetcher #(
    parameter int MAX_SRC_WID   = 640,
    parameter int MAX_SRC_HGT   = 480,
    parameter int IMG_WID       = MAX_SRC_WID,
    parameter int IMG_HGT       = MAX_SRC_HGT,
    parameter int DATA_DEPTH_BW = 16,
    parameter int H_SIZE_BW     = $clog2(MAX_SRC_WID),
    parameter int V_SIZE_BW     = $clog2(MAX_SRC_HGT)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    depth_neighbor_fetcher_if.slave  bus
);
    localparam int LBW = (IMG_WID > 1) ? $clog2(IMG_WID) : 1;

    typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [H_SIZE_BW-1:0]     in_u;
    logic [H_SIZE_BW-1:0]     in_u_nxt;
    logic [V_SIZE_BW-1:0]     in_v;
    logic [V_SIZE_BW-1:0]     in_v_nxt;
    logic [DATA_DEPTH_BW-1:0] lb [0:IMG_WID-1];

    logic                     accept;
    logic                     last_col;
    logic                     last_row;
    logic [LBW-1:0]           rd0_idx;
    logic [LBW-1:0]           rd1_idx;
    logic [DATA_DEPTH_BW-1:0] rd0;
    logic [DATA_DEPTH_BW-1:0] rd1;
    logic                     wr_en;
    logic [LBW-1:0]           wr_idx;

    logic                     vld_nxt;
    logic                     done_nxt;
    logic [DATA_DEPTH_BW-1:0] d0_nxt;
    logic [DATA_DEPTH_BW-1:0] du_nxt;
    logic [DATA_DEPTH_BW-1:0] dv_nxt;
    logic [H_SIZE_BW-1:0]     u_nxt;
    logic [V_SIZE_BW-1:0]     v_nxt;

    logic                     valid_q;
    logic                     done_q;
    logic [DATA_DEPTH_BW-1:0] d0_q;
    logic [DATA_DEPTH_BW-1:0] du_q;
    logic [DATA_DEPTH_BW-1:0] dv_q;
    logic [H_SIZE_BW-1:0]     u_q;
    logic [V_SIZE_BW-1:0]     v_q;

    assign bus.o_ready = (state != FLUSH);
    assign accept      = bus.i_valid && bus.o_ready;
    assign last_col    = (in_u == H_SIZE_BW'(IMG_WID - 1));
    assign last_row    = (in_v == V_SIZE_BW'(IMG_HGT - 1));

    // in_u doubles as the flush index, so both read ports serve stream and flush alike.
    assign rd0_idx = in_u[LBW-1:0];
    assign rd1_idx = last_col ? '0 : LBW'(rd0_idx + 1'b1);
    assign rd0     = lb[rd0_idx];
    assign rd1     = lb[rd1_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (accept && !bus.i_sof && last_col) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    if (bus.i_sof) begin
                        state_nxt = FILL;
                    end else if (last_col && last_row) begin
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (last_col) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        in_u_nxt = in_u;
        in_v_nxt = in_v;
        wr_en    = 1'b0;
        wr_idx   = rd0_idx;
        vld_nxt  = 1'b0;
        done_nxt = 1'b0;
        d0_nxt   = rd0;
        du_nxt   = last_col ? '0 : rd1;
        dv_nxt   = '0;
        u_nxt    = in_u;
        v_nxt    = V_SIZE_BW'(IMG_HGT - 1);
        if (state == FLUSH) begin
            vld_nxt  = 1'b1;
            done_nxt = last_col;
            in_u_nxt = last_col ? '0 : in_u + 1'b1;
            in_v_nxt = '0;
        end else if (accept) begin
            wr_en = 1'b1;
            if (bus.i_sof) begin
                // Resync: this pixel becomes (0,0) of a fresh frame.
                wr_idx   = '0;
                in_u_nxt = H_SIZE_BW'(1);
                in_v_nxt = '0;
            end else begin
                vld_nxt = (state == STREAM);
                dv_nxt  = bus.i_depth;
                v_nxt   = in_v - 1'b1;
                if (last_col) begin
                    in_u_nxt = '0;
                    in_v_nxt = last_row ? '0 : in_v + 1'b1;
                end else begin
                    in_u_nxt = in_u + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_u    <= '0;
            in_v    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            d0_q    <= '0;
            du_q    <= '0;
            dv_q    <= '0;
            u_q     <= '0;
            v_q     <= '0;
        end else begin
            in_u    <= in_u_nxt;
            in_v    <= in_v_nxt;
            valid_q <= vld_nxt;
            done_q  <= done_nxt;
            if (vld_nxt) begin
                d0_q <= d0_nxt;
                du_q <= du_nxt;
                dv_q <= dv_nxt;
                u_q  <= u_nxt;
                v_q  <= v_nxt;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            lb[wr_idx] <= bus.i_depth;
        end
    end

    assign bus.o_valid      = valid_q;
    assign bus.o_frame_done = done_q;
    assign bus.o_depth_0    = d0_q;
    assign bus.o_depth_u    = du_q;
    assign bus.o_depth_v    = dv_q;
    assign bus.o_u          = u_q;
    assign bus.o_v          = v_q;
endmodule

// File: tb/tb_depth_neighbor_fetcher.sv
// Bench for depth_neighbor_fetcher on a 4x3 frame: spot-value table, frame-level model, and corner sequences.
module tb_depth_neighbor_fetcher;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int DW   = 16;
    localparam int HB   = 10;
    localparam int VB   = 9;
    localparam int NPIX = W * H;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    depth_neighbor_fetcher_if #(.DATA_DEPTH_BW(DW), .H_SIZE_BW(HB), .V_SIZE_BW(VB)) bus ();

    depth_neighbor_fetcher #(
        .IMG_WID(W), .IMG_HGT(H), .DATA_DEPTH_BW(DW), .H_SIZE_BW(HB), .V_SIZE_BW(VB)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [DW-1:0] d0;
        logic [DW-1:0] du;
        logic [DW-1:0] dv;
        logic [HB-1:0] u;
        logic [VB-1:0] v;
        logic          done;
    } out_t;

    typedef struct {
        int base;
        int gap_pct;
        int u;
        int v;
        int d0;
        int du;
        int dv;
    } vec_t;

    out_t cap_q[$];
    out_t exp_q[$];
    int   pix[H][W];
    int   checks   = 0;
    int   errors   = 0;
    int   low_cnt  = 0;
    int   done_cnt = 0;
    vec_t vecs[4];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_valid) begin
                out_t r;
                r.d0   = bus.o_depth_0;
                r.du   = bus.o_depth_u;
                r.dv   = bus.o_depth_v;
                r.u    = bus.o_u;
                r.v    = bus.o_v;
                r.done = bus.o_frame_done;
                cap_q.push_back(r);
            end
            if (!bus.o_ready) low_cnt++;
            if (bus.o_frame_done) done_cnt++;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic gen_pattern(input int base);
        for (int v = 0; v < H; v++)
            for (int u = 0; u < W; u++)
                pix[v][u] = base + 100 * v + u + 1;
    endtask

    task automatic gen_random();
        for (int v = 0; v < H; v++)
            for (int u = 0; u < W; u++)
                pix[v][u] = int'($urandom_range(0, 65535));
    endtask

    // First k expected outputs of the current frame, in raster order.
    task automatic push_model(input int k);
        for (int j = 0; j < k; j++) begin
            out_t r;
            int   u;
            int   v;
            u      = j % W;
            v      = j / W;
            r.d0   = DW'(pix[v][u]);
            r.du   = (u < W - 1) ? DW'(pix[v][u+1]) : '0;
            r.dv   = (v < H - 1) ? DW'(pix[v+1][u]) : '0;
            r.u    = HB'(u);
            r.v    = VB'(v);
            r.done = (j == NPIX - 1);
            exp_q.push_back(r);
        end
    endtask

    task automatic drive_frame(input int npix, input int gap_pct);
        for (int j = 0; j < npix; j++) begin
            logic acc;
            int   guard;
            if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                bus.i_valid = 1'b0;
                bus.i_sof   = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            bus.i_valid = 1'b1;
            bus.i_sof   = (j == 0);
            bus.i_depth = DW'(pix[j / W][j % W]);
            guard = 0;
            do begin
                @(negedge clk);
                acc = bus.o_ready;
                @(posedge clk);
                #1;
                guard++;
            end while (!acc && guard < 64);
            if (!acc) chk("accept_timeout", acc, 1'b1);
        end
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_ready && n < 100);
        chk("idle_timeout", bus.o_ready, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic compare_q(input string name);
        int n;
        chk({name, "_count"}, cap_q.size(), exp_q.size());
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", name, i), cap_q[i], exp_q[i]);
    endtask

    task automatic new_section(output int low0, output int done0);
        cap_q.delete();
        exp_q.delete();
        low0  = low_cnt;
        done0 = done_cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int low0;
        int done0;

        vecs[0] = '{base: 0,    gap_pct: 0,  u: 1, v: 0, d0: 2,    du: 3,    dv: 102};
        vecs[1] = '{base: 0,    gap_pct: 0,  u: 3, v: 1, d0: 104,  du: 0,    dv: 204};
        vecs[2] = '{base: 0,    gap_pct: 40, u: 3, v: 2, d0: 204,  du: 0,    dv: 0};
        vecs[3] = '{base: 1000, gap_pct: 0,  u: 0, v: 0, d0: 1001, du: 1002, dv: 1101};

        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
        bus.i_depth = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", bus.o_valid, 1'b0);
        chk("rst_ready", bus.o_ready, 1'b1);
        chk("rst_done",  bus.o_frame_done, 1'b0);
        chk("rst_d0",    bus.o_depth_0, '0);
        chk("rst_du",    bus.o_depth_u, '0);
        chk("rst_dv",    bus.o_depth_v, '0);
        chk("rst_u",     bus.o_u, '0);
        chk("rst_v",     bus.o_v, '0);
        @(posedge clk);
        #1;

        // Table frames are driven back to back; each entry spot-checks one pixel of its frame.
        new_section(low0, done0);
        for (int i = 0; i < 4; i++) begin
            gen_pattern(vecs[i].base);
            drive_frame(NPIX, vecs[i].gap_pct);
            push_model(NPIX);
        end
        wait_idle();
        compare_q("table_frames");
        chk("table_ready_low", low_cnt - low0, 4 * W);
        chk("table_done_cnt", done_cnt - done0, 4);
        for (int i = 0; i < 4; i++) begin
            int idx;
            idx = i * NPIX + vecs[i].v * W + vecs[i].u;
            if (idx < cap_q.size())
                chk($sformatf("vec%0d_triple", i), {cap_q[idx].d0, cap_q[idx].du, cap_q[idx].dv},
                    {DW'(vecs[i].d0), DW'(vecs[i].du), DW'(vecs[i].dv)});
            else
                chk($sformatf("vec%0d_present", i), cap_q.size(), idx + 1);
        end

        // Flush timing relative to the edge that accepts the last pixel.
        new_section(low0, done0);
        gen_pattern(0);
        drive_frame(NPIX, 0);
        push_model(NPIX);
        @(negedge clk);
        chk("flush_t1_uv", {bus.o_valid, bus.o_u, bus.o_v}, {1'b1, HB'(3), VB'(1)});
        chk("flush_t1_ready", bus.o_ready, 1'b0);
        @(negedge clk);
        chk("flush_t2_uv", {bus.o_valid, bus.o_u, bus.o_v}, {1'b1, HB'(0), VB'(2)});
        chk("flush_t2_data", {bus.o_depth_0, bus.o_depth_u, bus.o_depth_v}, {DW'(201), DW'(202), DW'(0)});
        chk("flush_t2_ready", bus.o_ready, 1'b0);
        @(negedge clk);
        chk("flush_t3_ready", bus.o_ready, 1'b0);
        @(negedge clk);
        chk("flush_t4_ready", bus.o_ready, 1'b0);
        @(negedge clk);
        chk("flush_t5_ready", bus.o_ready, 1'b1);
        chk("flush_t5_done", {bus.o_frame_done, bus.o_u, bus.o_v}, {1'b1, HB'(3), VB'(2)});
        wait_idle();
        compare_q("flush_frame");

        // Random depths with random input bubbles.
        new_section(low0, done0);
        gen_random();
        drive_frame(NPIX, 50);
        push_model(NPIX);
        wait_idle();
        compare_q("bubble_frame");
        chk("bubble_ready_low", low_cnt - low0, W);

        // Resync: sof on input pixel 6 abandons the partial frame.
        new_section(low0, done0);
        gen_pattern(0);
        drive_frame(6, 0);
        push_model(6 - W);
        gen_pattern(2000);
        drive_frame(NPIX, 0);
        push_model(NPIX);
        wait_idle();
        compare_q("resync");
        chk("resync_done_cnt", done_cnt - done0, 1);

        // Reset after two flush outputs have been observed.
        new_section(low0, done0);
        gen_random();
        drive_frame(NPIX, 0);
        push_model(NPIX - W + 2);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rstflush_valid", bus.o_valid, 1'b0);
        chk("rstflush_ready", bus.o_ready, 1'b1);
        chk("rstflush_done",  bus.o_frame_done, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        compare_q("rstflush_partial");
        chk("rstflush_done_cnt", done_cnt - done0, 0);

        new_section(low0, done0);
        gen_random();
        drive_frame(NPIX, 20);
        push_model(NPIX);
        wait_idle();
        compare_q("post_reset_frame");
        chk("post_reset_done_cnt", done_cnt - done0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/depth_neighbor_fetcher.md
Name: depth_neighbor_fetcher

Overview:
- Raster-order depth streamer feeding the normal computer.
- Accepts one depth pixel per cycle in raster order (u fastest).
- For every pixel (u,v), emits the neighbourhood triple: d(u,v), d(u+1,v), d(u,v+1), plus the coordinates u and v.
- Uses a single-row line buffer. Rows 0..H-2 stream while the next row arrives; the last row is drained in a flush phase with input stalled.

Parameters:
- IMG_WID, default MAX_SRC_WID (640): pixels per row; must be ≥2.
- IMG_HGT, default MAX_SRC_HGT (480): rows per frame; must be ≥2.

Ports:
- i_clk, input, 1: clock.
- i_rst_n, input, 1: reset. Asynchronous, active-low.
- i_valid, input, 1: input pixel valid. Pixel is accepted when i_valid && o_ready.
- i_sof, input, 1: start-of-frame flag, qualified with an accepted pixel.
- i_depth, input, DATA_DEPTH_BW: input depth.
- o_ready, output, 1: block can accept input.
- o_valid, output, 1: output triple valid.
- o_depth_0, output, DATA_DEPTH_BW: d(u,v).
- o_depth_u, output, DATA_DEPTH_BW: d(u+1,v); 0 when u=IMG_WID-1.
- o_depth_v, output, DATA_DEPTH_BW: d(u,v+1); 0 when v=IMG_HGT-1.
- o_u, output, H_SIZE_BW: column of the output pixel.
- o_v, output, V_SIZE_BW: row of the output pixel.
- o_frame_done, output, 1: one-cycle pulse, coincident with o_valid for pixel (IMG_WID-1, IMG_HGT-1).

Behaviour:
- Reset values:
  - All registered outputs 0.
  - State FILL; input counters in_u=0, in_v=0.
  - o_ready=1; line buffer contents don't-care.
- Storage:
  - Line buffer lb[0..IMG_WID-1] of DATA_DEPTH_BW bits, register array.
  - Two combinational read ports (lb[in_u], lb[in_u+1]) plus one write port, all in the same cycle. Read occurs before write.
- Input counters:
  - Advance on every accepted pixel: in_u wraps at IMG_WID-1 and increments in_v.
  - Every accepted pixel writes lb[in_u] <= i_depth.
- State FILL (row 0 arriving):
  - No outputs produced.
  - Accepting (IMG_WID-1, 0) moves the state to STREAM.
- State STREAM (rows 1..IMG_HGT-1 arriving). On accepting pixel (u,v), the next cycle shows the output for pixel (u, v-1):
  - o_valid=1
  - o_depth_0 = old lb[u]
  - o_depth_u = old lb[u+1] (row v-1 value, not yet overwritten); 0 if u=IMG_WID-1
  - o_depth_v = i_depth
  - o_u = u, o_v = v-1
  - Accepting (IMG_WID-1, IMG_HGT-1) moves the state to FLUSH, with flush index f=0.
- State FLUSH:
  - o_ready=0.
  - Each cycle registers the output for (f, IMG_HGT-1): d0 = lb[f], du = lb[f+1] (0 at the last column), dv = 0.
  - f increments each cycle. After f=IMG_WID-1: state FILL, counters 0, o_frame_done registered with that output.
- Timing:
  - Output latency is 1 cycle from the accepting edge (stream) or from the flush cycle.
  - o_valid otherwise 0; other data outputs hold their last values.
  - Gaps in i_valid produce matching gaps in o_valid; no other effect.
  - Per frame: exactly IMG_WID*IMG_HGT outputs, in raster order. o_ready is low for exactly IMG_WID cycles.
- i_sof on an accepted pixel in FILL or STREAM:
  - Pixel is treated as (0,0): counters are forced so this pixel writes lb[0], then in_u=1, in_v=0.
  - State becomes FILL and the partial frame is abandoned. No flush, no o_frame_done.
  - No output is generated for that pixel. Outputs already registered still appear.
- i_sof on a pixel that is already (0,0) in FILL: no effect beyond normal behaviour.
- Reset mid-operation (including FLUSH): immediate return to reset values; the pending flush is discarded.
- No downstream backpressure: the consumer is a fixed-latency pipeline.

Test Plan:
- Steady frame: IMG_WID=4, IMG_HGT=3, d = 100*v + u + 1, i_valid always high.
  - (1,0) -> d0=2, du=3, dv=102.
  - (3,1) -> d0=104, du=0, dv=204.
  - 12 outputs in raster order; o_ready low exactly 4 cycles.
  - o_frame_done with (3,2): d0=204, du=0, dv=0.
- Flush timing: last input accepted at cycle T -> outputs (3,1) at T+1 and (0,2) at T+2 (d0=201, du=202, dv=0). o_ready returns to 1 at T+5.
- Bubbles: random i_valid gaps over the same frame -> identical output sequence; o_valid count = 12; no duplicated or lost pixel.
- Back-to-back frames: second frame (d + 1000) offered immediately. It is stalled only during flush; (0,0) of frame 2 -> d0=1001, du=1002, dv=1101.
- Mid-frame resync: i_sof asserted at input pixel index 6 (row 1) -> no o_frame_done. The next 12 pixels form a full frame with correct triples.
- Reset during FLUSH (after 2 flush outputs): o_valid=0, o_ready=1, o_frame_done never pulses. A following full frame is correct.
